// File: rtl/core_pkg.sv
// Shared definitions for the 9-bit-instruction core: sequencer states,
// next-PC selects, instruction-type and opcode constants.
package core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEM_WAIT,
      HALT
   } seq_state_t;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INC,
      PC_TARGET,
      PC_CLEAR
   } pc_sel_t;

   localparam logic ITYPE_RUN = 1'b0;
   localparam logic ITYPE_PUT = 1'b1;

   localparam logic [3:0] OP_LOAD  = 4'b0001;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_JUMP  = 4'b1000;
   localparam logic [3:0] OP_BEQ   = 4'b1001;
   localparam logic [3:0] OP_BLT   = 4'b1010;
   localparam logic [3:0] OP_BGT   = 4'b1011;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with its next-PC mux.
// Increment wraps naturally at 2^PC_W.
module pc_unit
   import core_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  pc_sel_t         sel,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
      end else begin
         unique case (sel)
            PC_HOLD:   pc <= pc;
            PC_INC:    pc <= pc + PC_ONE;
            PC_TARGET: pc <= target;
            PC_CLEAR:  pc <= '0;
            default:   pc <= pc;
         endcase
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM_WAIT sequencer: owns the PC, redirects on
// jump/branch, holds the data-memory handshake and stops on HALT.
module fetch_sequencer
   import core_pkg::*;
#(
   parameter int PC_W        = 10,
   parameter int MEM_TIMEOUT = 15,
   parameter int RET_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [8:0]       instr_in,
   input  logic             branch_cond,
   input  logic [PC_W-1:0]  target,
   input  logic             mem_ack,
   output logic [PC_W-1:0]  imem_addr,
   output logic [8:0]       instr_q,
   output logic             mem_req,
   output logic             mem_we,
   output logic             commit,
   output logic             busy,
   output logic             done,
   output logic             mem_err,
   output logic [RET_W-1:0] retired
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [RET_W-1:0] RET_ONE  = RET_W'(1);

   seq_state_t       state;
   pc_sel_t          pc_sel;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       op;
   logic             run;
   logic             is_halt;
   logic             is_mem;
   logic             take;
   logic [RET_W-1:0] ret_nx;

   assign op      = instr_q[4:1];
   assign run     = (instr_q[0] == ITYPE_RUN);
   assign is_halt = run && (op == OP_HALT);
   assign is_mem  = run && ((op == OP_LOAD) || (op == OP_STORE));
   assign take    = run && ((op == OP_JUMP) ||
                            (is_branch(op) && branch_cond));
   assign ret_nx  = (&retired) ? retired : retired + RET_ONE;

   always_comb begin
      pc_sel = PC_HOLD;
      unique case (state)
         IDLE, HALT: begin
            if (start) pc_sel = PC_CLEAR;
         end
         EXEC: begin
            if (!is_halt && !is_mem)
               pc_sel = take ? PC_TARGET : PC_INC;
         end
         MEM_WAIT: begin
            if (mem_ack) pc_sel = PC_INC;
         end
         default: pc_sel = PC_HOLD;
      endcase
   end

   pc_unit #(
      .PC_W(PC_W)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .sel   (pc_sel),
      .target(target),
      .pc    (imem_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         instr_q  <= '0;
         retired  <= '0;
         wait_cnt <= '0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         commit   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         commit <= 1'b0;
         unique case (state)
            IDLE, HALT: begin
               if (start) begin
                  state   <= FETCH;
                  retired <= '0;
                  mem_err <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            FETCH: begin
               instr_q <= instr_in;
               state   <= EXEC;
            end
            EXEC: begin
               if (is_halt) begin
                  state <= HALT;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (is_mem) begin
                  mem_req  <= 1'b1;
                  mem_we   <= (op == OP_STORE);
                  wait_cnt <= '0;
                  state    <= MEM_WAIT;
               end else begin
                  commit  <= 1'b1;
                  retired <= ret_nx;
                  state   <= FETCH;
               end
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  commit  <= 1'b1;
                  retired <= ret_nx;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= FETCH;
               end else if (wait_cnt == TMO_LAST) begin
                  // No ack within the window: abandon the access.
                  mem_err <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= HALT;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an instruction-level model
// predicts commits, memory accesses and the final halt state.
module tb_fetch_sequencer;
   import core_pkg::*;

   localparam int PC_W  = 10;
   localparam int MT    = 15;
   localparam int RW    = 4;
   localparam int DEPTH = 1 << PC_W;
   localparam int RMAX  = (1 << RW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [8:0]      instr_in;
   logic            branch_cond;
   logic [PC_W-1:0] target;
   logic            mem_ack;
   logic [PC_W-1:0] imem_addr;
   logic [8:0]      instr_q;
   logic            mem_req;
   logic            mem_we;
   logic            commit;
   logic            busy;
   logic            done;
   logic            mem_err;
   logic [RW-1:0]   retired;

   fetch_sequencer #(
      .PC_W(PC_W), .MEM_TIMEOUT(MT), .RET_W(RW)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .instr_in(instr_in), .branch_cond(branch_cond),
      .target(target), .mem_ack(mem_ack),
      .imem_addr(imem_addr), .instr_q(instr_q),
      .mem_req(mem_req), .mem_we(mem_we), .commit(commit),
      .busy(busy), .done(done), .mem_err(mem_err),
      .retired(retired)
   );

   always #5 clk = ~clk;

   logic [8:0]      imem [DEPTH];
   logic [PC_W-1:0] tgt  [DEPTH];
   logic            cnd  [DEPTH];
   int              dly  [DEPTH];

   logic start_main  = 1'b0;
   logic start_noise = 1'b0;
   logic ack_noise   = 1'b0;
   logic noise_en    = 1'b0;
   int   reqcnt      = 0;
   int   cyc         = 0;
   int   start_cyc   = 0;
   int   total       = 0;
   int   bad         = 0;

   assign start       = start_main | start_noise;
   assign instr_in    = imem[imem_addr];
   assign target      = tgt[imem_addr];
   assign branch_cond = cnd[imem_addr];
   assign mem_ack     = mem_req ? (reqcnt == dly[imem_addr]) : ack_noise;

   always @(posedge clk) reqcnt <= mem_req ? reqcnt + 1 : 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      start_noise = noise_en && busy && ($urandom_range(7) == 0);
      ack_noise   = noise_en && ($urandom_range(3) == 0);
   end

   typedef struct {
      logic [PC_W-1:0] pc;
      logic [RW-1:0]   ret;
   } cexp_t;

   cexp_t commitq[$];
   logic  memq[$];
   int    commit_log[$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pops predictions whenever the DUT commits or requests memory.
   logic prev_commit = 1'b0;
   logic prev_req    = 1'b0;
   logic exp_we      = 1'b0;
   always @(negedge clk) begin : mon
      cexp_t e;
      if (commit) begin
         commit_log.push_back(cyc);
         check("commit_gap", prev_commit, 0);
         if (commitq.size() == 0) begin
            check("commit_unexpected", commit, 0);
         end else begin
            e = commitq.pop_front();
            check("commit_pc", imem_addr, e.pc);
            check("commit_retired", retired, e.ret);
         end
      end
      if (mem_req && !prev_req) begin
         if (memq.size() == 0) begin
            check("mem_req_unexpected", mem_req, 0);
         end else begin
            exp_we = memq.pop_front();
            check("mem_we", mem_we, exp_we);
         end
      end else if (mem_req) begin
         check("mem_we_hold", mem_we, exp_we);
      end
      prev_commit = commit;
      prev_req    = mem_req;
   end

   function automatic logic [8:0] enc(input logic it, input logic [3:0] op);
      logic [3:0] hi;
      hi = 4'($urandom);
      return {hi, op, it};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) begin
         imem[i] = enc(1'b0, 4'd15);
         tgt[i]  = '0;
         cnd[i]  = 1'b0;
         dly[i]  = 0;
      end
   endtask

   task automatic rand_mem();
      for (int i = 0; i < DEPTH; i++) begin
         int k;
         k = $urandom_range(99);
         if (k < 35)      imem[i] = enc(1'b1, 4'($urandom));
         else if (k < 45) imem[i] = enc(1'b0, 4'd1);
         else if (k < 55) imem[i] = enc(1'b0, 4'd2);
         else if (k < 63) imem[i] = enc(1'b0, 4'd8);
         else if (k < 78) imem[i] = enc(1'b0, 4'(9 + $urandom_range(2)));
         else if (k < 82) imem[i] = enc(1'b0, 4'd15);
         else             imem[i] = enc(1'b0, 4'($urandom_range(3, 7)));
         tgt[i] = PC_W'($urandom_range(DEPTH - 1));
         cnd[i] = 1'($urandom_range(1));
         dly[i] = ($urandom_range(9) == 0) ? $urandom_range(MT, MT + 15)
                                           : $urandom_range(0, MT - 1);
      end
   endtask

   // Instruction-level reference: walks the program, queues predictions.
   task automatic model_run(input int maxk, output bit halted,
                            output logic [PC_W-1:0] fpc,
                            output logic [RW-1:0] fret, output bit ferr);
      int pc, ret, n, nxt;
      bit cm;
      logic [8:0] w;
      int op;
      pc = 0; ret = 0; n = 0; halted = 0; ferr = 0;
      while (!halted && n < maxk) begin
         w  = imem[pc];
         op = int'(w[4:1]);
         cm = 1;
         nxt = (pc + 1) % DEPTH;
         if (w[0] == 1'b0) begin
            if (op == 15) begin
               halted = 1; cm = 0;
            end else if (op == 1 || op == 2) begin
               memq.push_back(op == 2);
               if (dly[pc] >= MT) begin
                  halted = 1; ferr = 1; cm = 0;
               end
            end else if (op == 8) begin
               nxt = int'(tgt[pc]);
            end else if (op >= 9 && op <= 11) begin
               if (cnd[pc]) nxt = int'(tgt[pc]);
            end
         end
         if (cm) begin
            pc  = nxt;
            ret = (ret < RMAX) ? ret + 1 : RMAX;
            commitq.push_back('{PC_W'(pc), RW'(ret)});
            n++;
         end
      end
      fpc  = PC_W'(pc);
      fret = RW'(ret);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_state",
            {imem_addr, instr_q, mem_req, mem_we, commit,
             busy, done, mem_err, retired}, 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_main = 1'b1;
      start_cyc  = cyc;
      @(negedge clk);
      start_main = 1'b0;
      check("start_state", {busy, done, mem_err, imem_addr, retired},
            {1'b1, 1'b0, 1'b0, {PC_W{1'b0}}, {RW{1'b0}}});
   endtask

   task automatic run_prog(input int maxk);
      bit h, e;
      logic [PC_W-1:0] p;
      logic [RW-1:0]   r;
      int t;
      model_run(maxk, h, p, r, e);
      pulse_start();
      t = 0;
      while ((commitq.size() != 0 || memq.size() != 0 || (h && !done))
             && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 3000) begin
         check("run_wait_expired", t, 0);
         commitq.delete();
         memq.delete();
         do_reset();
      end else if (h) begin
         @(negedge clk);
         check("halt_state",
               {done, busy, commit, mem_err, imem_addr, retired},
               {1'b1, 1'b0, 1'b0, e, p, r});
      end else begin
         do_reset();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset = 1'b1;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // add, xor, halt: commit strobes 3 and 5 cycles after start
      imem[0] = enc(1'b0, 4'd0);
      imem[1] = enc(1'b1, 4'd3);
      commit_log.delete();
      run_prog(50);
      check("t1_ncommit", commit_log.size(), 2);
      if (commit_log.size() == 2) begin
         check("t1_commit0_cyc", commit_log[0] - start_cyc, 3);
         check("t1_commit1_cyc", commit_log[1] - start_cyc, 5);
      end

      // jump, branches, store with delayed ack, load timeout
      clear_mem();
      imem[0]     = enc(1'b0, 4'd8);  tgt[0] = 10'h155;
      imem[10'h155] = enc(1'b0, 4'd8);
      tgt[10'h155]  = 10'd7;
      cnd[10'h155]  = 1'b1;
      imem[7] = enc(1'b0, 4'd9); tgt[7] = 10'd40; cnd[7] = 1'b0;
      imem[8] = enc(1'b0, 4'd9); tgt[8] = 10'd3;  cnd[8] = 1'b1;
      imem[3] = enc(1'b0, 4'd0);
      imem[4] = enc(1'b0, 4'd2); dly[4] = 3;
      imem[5] = enc(1'b0, 4'd1); dly[5] = 1000;
      run_prog(50);

      // restart after timeout must clear mem_err
      imem[5] = enc(1'b0, 4'd1); dly[5] = MT - 1;
      imem[6] = enc(1'b0, 4'd15);
      run_prog(50);

      // wrap from all-ones back to 0, cut off by reset
      clear_mem();
      imem[0]       = enc(1'b0, 4'd8); tgt[0] = 10'h3FF;
      imem[DEPTH-1] = enc(1'b1, 4'd8);
      run_prog(7);

      // reset in the middle of a memory wait
      clear_mem();
      imem[0] = enc(1'b0, 4'd1); dly[0] = 1000;
      memq.push_back(1'b0);
      pulse_start();
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = mem_req;
      end
      check("mw_req_seen", ok, 1);
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      check("mw_memq_drained", memq.size(), 0);

      // randomized programs with start/ack noise
      noise_en = 1'b1;
      for (int n = 0; n < 30; n++) begin
         rand_mem();
         run_prog($urandom_range(5, 40));
      end
      noise_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction sequencer for the 9-bit-instruction core.
- Owns the program counter and steps each instruction through FETCH → EXEC (→ MEM_WAIT) → commit.
- Handles jump/branch redirection, holds the core during data-memory handshakes, and stops on HALT.
- Sits between instruction memory, the control decoder, the ALU condition output and data memory.

Parameters:
PC_W, 10, program counter / instruction address width
MEM_TIMEOUT, 15, max cycles to wait for mem_ack before flagging an error (must be ≥1)
RET_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin execution from PC 0 (ignored outside IDLE/HALT)
instr_in  in  9  instruction read combinationally from imem at imem_addr
branch_cond  in  1  ALU compare result for the instruction in EXEC (1 = taken)
target  in  PC_W  jump/branch destination from the register file
mem_ack  in  1  data memory completes the request this cycle
imem_addr  out  PC_W  current PC
instr_q  out  9  latched instruction presented to the decoder/datapath
mem_req  out  1  data memory request, held until acknowledged
mem_we  out  1  1 = store, 0 = load; valid while mem_req=1
commit  out  1  one-cycle strobe; qualifies regfile write and PC update
busy  out  1  1 in FETCH/EXEC/MEM_WAIT
done  out  1  1 in HALT
mem_err  out  1  sticky; set on memory timeout
retired  out  RET_W  committed-instruction count, saturating

Behaviour:
Reset values:
- State IDLE; pc, instr_q, retired and timeout counter = 0.
- mem_req, mem_we, commit, busy, done and mem_err = 0.
- Reset wins over every other event in the same cycle, including mid-MEM_WAIT; mem_req drops the next cycle.

Instruction field decode (itype = instr_q[0], op = instr_q[4:1]):
- Run type is itype=0.
- op 0001 = load, 0010 = store, 1000 = jump, 1001–1011 = conditional branch, 1111 = halt.
- Put type (itype=1) is a plain 1-cycle commit.

IDLE:
- Outputs idle.
- start → FETCH, with pc=0, retired=0 and mem_err cleared.

FETCH (1 cycle):
- instr_q ← instr_in, then → EXEC.

EXEC:
- halt → HALT. No commit; pc is not advanced.
- load/store:
  - Registered mem_req=1 with mem_we=(op==0010); → MEM_WAIT.
  - Timeout counter cleared.
- Otherwise:
  - commit=1.
  - PC update:
    - jump: pc ← target.
    - branch with branch_cond=1: pc ← target.
    - else: pc ← pc+1, modulo 2^PC_W (wraps from all-ones to 0).
  - → FETCH.
- branch_cond is sampled only for op 1001–1011 and is ignored otherwise.

MEM_WAIT:
- mem_req and mem_we are held stable.
- mem_ack=1: commit=1, pc ← pc+1, mem_req=0 the next cycle, → FETCH.
- mem_ack=0: counter increments. When the counter reaches MEM_TIMEOUT without ack: mem_err ← 1, mem_req ← 0, → HALT (no commit).
- mem_ack outside MEM_WAIT is ignored.

HALT:
- done=1 and busy=0; pc holds.
- start → FETCH with pc=0, retired=0 and mem_err cleared.

General rules:
- retired increments on every commit and saturates at all-ones.
- commit is asserted only in the cycle the PC update takes effect and is never asserted in consecutive cycles.
- A non-load/store instruction takes 2 cycles; load/store takes 3 + ack-wait cycles.
- start arriving during busy has no effect.

Decomposition:
- Shared package `core_pkg`:
  - typedef seq_state_t {IDLE, FETCH, EXEC, MEM_WAIT, HALT}
  - opcode constants OP_LOAD, OP_STORE, OP_JUMP, OP_BEQ, OP_BLT, OP_BGT, OP_HALT
  - ITYPE_RUN/ITYPE_PUT
  - the same package is imported by the control decoder
- Sub-module `pc_unit`: PC register with next-PC mux (hold / +1 / target / clear). Everything else stays in `fetch_sequencer`.

Test Plan:
1. Reset then start; imem = add, xor, halt at 0–2 → commit pulses at cycles 3 and 5 after start; done=1 with pc=2; retired=2.
2. EXEC holds a jump (op 1000) with target=0x155 → next imem_addr=0x155; commit=1 for one cycle; branch_cond is ignored.
3. beq with branch_cond=0 at pc=7 → pc=8. beq with branch_cond=1 and target=3 → pc=3.
4. Store at pc=4 with mem_ack after 3 wait cycles:
   - mem_req=1 and mem_we=1, stable for 3 cycles.
   - commit coincides with ack; pc=5; mem_req=0 next cycle.
5. Load with mem_ack never asserted, MEM_TIMEOUT=15 → after 15 wait cycles: mem_err=1, done=1, no commit. A following start clears mem_err and restarts at pc=0.
6. Wrap and reset cases:
   - PC_W=4, pc=15, non-branch instruction → pc wraps to 0.
   - reset asserted during MEM_WAIT → next cycle all outputs are at reset values and the state is IDLE.
